fft16_input_framer: RTL

- Upstream neighbour of the stage-1 butterfly array.
- Collects a serial stream of complex samples into 16-point frames using two ping-pong banks.
- Presents each complete frame as flattened N*WIDTH real/imag buses under a valid/ready handshake.
- Supports continuous one-sample-per-cycle input, provided the consumer accepts each frame within 16 cycles.

---
 rtl/fft16_pkg.sv | 17 +
 rtl/fft16_frame_bank.sv | 41 ++++
 rtl/fft16_input_framer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fft16_pkg.sv
// Shared types and helpers for the 16-point FFT input framer.
// Holds default sizes, the sample type and the 4-bit bit-reverse helper.
package fft16_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int N_DEF     = 16;
  localparam int ADDR_W    = 4;

  typedef logic signed [WIDTH_DEF-1:0] sample_t;

  function automatic logic [ADDR_W-1:0] bitrev4(
    input logic [ADDR_W-1:0] a
  );
    return {a[0], a[1], a[2], a[3]};
  endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-entry {real, imag} register bank, single write port.
// Ports: clk, rst (sync, active-high), i_we/i_waddr/i_wxr/i_wxi write,
// o_xr/o_xi flattened read (entry k at bits [(k+1)*WIDTH-1 : k*WIDTH]).
module fft16_frame_bank
  import fft16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [WIDTH-1:0]   i_wxr,
  input  logic [WIDTH-1:0]   i_wxi,
  output logic [N*WIDTH-1:0] o_xr,
  output logic [N*WIDTH-1:0] o_xi
);

  logic [WIDTH-1:0] r_xr [N];
  logic [WIDTH-1:0] r_xi [N];

  for (genvar k = 0; k < N; k++) begin : g_ent
    logic w_hit;
    assign w_hit = i_we && (i_waddr == ADDR_W'(k));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_xr[k] <= '0;
        r_xi[k] <= '0;
      end else if (w_hit) begin
        r_xr[k] <= i_wxr;
        r_xi[k] <= i_wxi;
      end
    end

    assign o_xr[k*WIDTH +: WIDTH] = r_xr[k];
    assign o_xi[k*WIDTH +: WIDTH] = r_xi[k];
  end

endmodule

// File: rtl/fft16_input_framer.sv
// Ping-pong framer: serial complex samples -> 16-point flattened frames.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_last,
// xr_in/xi_in sample input; out_valid/out_ready, out_xr/out_xi frame
// output (point k at bits [(k+1)*WIDTH-1 : k*WIDTH]); err_framing pulse.
// Build option: define FFT16_INPUT_BITREV_EN to store frames in
// bit-reversed point order (DIT stage-1 input order).
module fft16_input_framer
  import fft16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [WIDTH-1:0]   xr_in,
  input  logic [WIDTH-1:0]   xi_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_xr,
  output logic [N*WIDTH-1:0] out_xi,
  output logic               err_framing
);

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_idx;
  logic              r_err;

  logic              w_accept;
  logic              w_consume;
  logic              w_idx_end;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we0;
  logic              w_we1;

  logic [N*WIDTH-1:0] w_b0_xr;
  logic [N*WIDTH-1:0] w_b0_xi;
  logic [N*WIDTH-1:0] w_b1_xr;
  logic [N*WIDTH-1:0] w_b1_xi;

  assign in_ready  = ~r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;
  assign w_idx_end = (r_wr_idx == ADDR_W'(N - 1));

`ifdef FFT16_INPUT_BITREV_EN
  assign w_addr = bitrev4(r_wr_idx);
`else
  assign w_addr = r_wr_idx;
`endif

  assign w_we0 = w_accept & ~r_wr_bank;
  assign w_we1 = w_accept &  r_wr_bank;

  fft16_frame_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we0),
    .i_waddr (w_addr),
    .i_wxr   (xr_in),
    .i_wxi   (xi_in),
    .o_xr    (w_b0_xr),
    .o_xi    (w_b0_xi)
  );

  fft16_frame_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we1),
    .i_waddr (w_addr),
    .i_wxr   (xr_in),
    .i_wxi   (xi_in),
    .o_xr    (w_b1_xr),
    .o_xi    (w_b1_xi)
  );

  // A completing write and a consume never target the same bank:
  // the write bank is only writable while its full flag is clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (w_idx_end) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_idx          <= '0;
          r_err             <= ~in_last;
        end else if (in_last) begin
          // Short frame: drop it, the bank is simply rewritten.
          r_wr_idx <= '0;
          r_err    <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_consume) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end

  assign err_framing = r_err;

  always_comb begin
    out_xr = '0;
    out_xi = '0;
    if (out_valid) begin
      out_xr = r_rd_bank ? w_b1_xr : w_b0_xr;
      out_xi = r_rd_bank ? w_b1_xi : w_b0_xi;
    end
  end

endmodule
